// File: rtl/dft_pkg.sv
// Shared definitions for the DFT bin array consumers: default frame geometry,
// the bin word type and the reader state encoding.
package dft_pkg;

    localparam int DFT_BINCOUNT = 120;
    localparam int DFT_INW      = 36;
    localparam int DFT_OUTW     = 32;
    localparam int DFT_SHIFT    = 0;

    typedef logic [DFT_INW-1:0] bin_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } reader_state_t;

endpackage

// File: rtl/bin_scale.sv
// Width reduction of one magnitude bin: right shift by SHIFT, then clamp to
// the largest OUTW-bit value if any significant bit remains above OUTW.
module bin_scale #(
    parameter int INW   = 36,
    parameter int OUTW  = 32,
    parameter int SHIFT = 0
) (
    input  logic [INW-1:0]  bin_in,
    output logic [OUTW-1:0] bin_out
);

    logic [INW-1:0] shifted;

    assign shifted = bin_in >> SHIFT;

    generate
        if (INW > OUTW) begin : g_sat
            logic overflow;
            assign overflow = |shifted[INW-1:OUTW];
            assign bin_out  = overflow ? {OUTW{1'b1}} : shifted[OUTW-1:0];
        end else begin : g_wide
            assign bin_out = OUTW'(shifted);
        end
    endgenerate

endmodule

// File: rtl/dft_bin_reader.sv
// Snapshot reader for the DFT bin array: freezes every bin into a local bank in
// one cycle and streams the frozen frame out one scaled bin per valid/ready beat.
module dft_bin_reader
    import dft_pkg::*;
#(
    parameter int BINCOUNT = DFT_BINCOUNT,
    parameter int INW      = DFT_INW,
    parameter int OUTW     = DFT_OUTW,
    parameter int SHIFT    = DFT_SHIFT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [INW-1:0]              inBins [0:BINCOUNT-1],
    input  logic                        snapshot,
    output logic [OUTW-1:0]             outData,
    output logic [$clog2(BINCOUNT)-1:0] outIndex,
    output logic                        outValid,
    input  logic                        outReady,
    output logic                        outFirst,
    output logic                        outLast,
    output logic                        busy,
    output logic [7:0]                  overrunCount
);

    localparam int IDXW = $clog2(BINCOUNT);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BINCOUNT - 1);

    reader_state_t   state_q, state_d;
    logic [IDXW-1:0] index_q, index_d;
    logic            pending_q, pending_d;
    logic [7:0]      overrun_q, overrun_d;
    logic [INW-1:0]  bank_q [0:BINCOUNT-1];
    logic [INW-1:0]  bank_d [0:BINCOUNT-1];

    logic            streaming;
    logic            xfer;
    logic            at_last;
    logic            capture;
    logic [OUTW-1:0] scaled;

    assign streaming = (state_q == STREAM);
    assign xfer      = streaming && outReady;
    assign at_last   = (index_q == LAST_IDX);

    // A request that lands on the last-beat edge is served by recapture and never
    // becomes pending; any other request during a frame is remembered once.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (snapshot) begin
                    capture = 1'b1;
                    index_d = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer && at_last) begin
                    index_d = '0;
                    if (pending_q || snapshot) begin
                        capture   = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        index_d = index_q + 1'b1;
                    end
                    if (snapshot) begin
                        if (!pending_q) begin
                            pending_d = 1'b1;
                        end else if (overrun_q != 8'hFF) begin
                            overrun_d = overrun_q + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < BINCOUNT; i++) begin
            bank_d[i] = capture ? inBins[i] : bank_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            index_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // The bank holds data only; its contents are irrelevant until a capture.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BINCOUNT; i++) begin
            bank_q[i] <= bank_d[i];
        end
    end

    bin_scale #(
        .INW   (INW),
        .OUTW  (OUTW),
        .SHIFT (SHIFT)
    ) u_bin_scale (
        .bin_in  (bank_q[index_q]),
        .bin_out (scaled)
    );

    assign outValid     = streaming;
    assign outIndex     = index_q;
    assign outData      = streaming ? scaled : '0;
    assign outFirst     = streaming && (index_q == '0);
    assign outLast      = streaming && at_last;
    assign busy         = streaming || pending_q;
    assign overrunCount = overrun_q;

endmodule

// File: tb/tb_dft_bin_reader.sv
// Self-checking bench for dft_bin_reader: two instances (SHIFT=0 and SHIFT=4) run
// in lockstep; captured frames are queued as expected beats and popped on transfer.
module tb_dft_bin_reader;

    localparam int NB = 120;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        snapshot = 1'b0;
    logic        outReady = 1'b0;
    logic [35:0] inBins [0:NB-1];

    logic [31:0] outData, outData4;
    logic [6:0]  outIndex, outIndex4;
    logic        outValid, outValid4, outFirst, outFirst4, outLast, outLast4, busy, busy4;
    logic [7:0]  overrunCount, overrunCount4;

    dft_bin_reader #(.BINCOUNT(NB), .INW(36), .OUTW(32), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .inBins(inBins), .snapshot(snapshot),
        .outData(outData), .outIndex(outIndex), .outValid(outValid), .outReady(outReady),
        .outFirst(outFirst), .outLast(outLast), .busy(busy), .overrunCount(overrunCount)
    );

    dft_bin_reader #(.BINCOUNT(NB), .INW(36), .OUTW(32), .SHIFT(4)) dut4 (
        .clk(clk), .rst(rst), .inBins(inBins), .snapshot(snapshot),
        .outData(outData4), .outIndex(outIndex4), .outValid(outValid4), .outReady(outReady),
        .outFirst(outFirst4), .outLast(outLast4), .busy(busy4), .overrunCount(overrunCount4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] d0;
        logic [31:0] d4;
    } beat_t;

    typedef struct {
        int          idx;
        logic [35:0] value;
        logic [31:0] exp0;
        logic [31:0] exp4;
    } vec_t;

    beat_t       sbq[$];
    beat_t       monExp;
    vec_t        vecs [0:7];
    logic [31:0] got0 [0:NB-1];
    logic [31:0] got4 [0:NB-1];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] scaleRef(input logic [35:0] x, input int sh);
        logic [35:0] y;
        y = x >> sh;
        return (y > 36'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : y[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushFrame();
        for (int i = 0; i < NB; i++) begin
            sbq.push_back('{i, scaleRef(inBins[i], 0), scaleRef(inBins[i], 4)});
        end
    endtask

    task automatic fillRandom();
        logic [63:0] r;
        for (int i = 0; i < NB; i++) begin
            r = {$urandom(), $urandom()};
            inBins[i] = r[35:0];
        end
    endtask

    task automatic applyStimulus();
        snapshot = 1'b1;
        pushFrame();
        tick();
        snapshot = 1'b0;
    endtask

    task automatic waitIndex(input int idx);
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (outValid && outIndex == 7'(idx)) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL wait_index: index %0d never shown, got %0d", idx, outIndex);
    endtask

    task automatic waitIdle();
        for (int c = 0; c < 3000; c++) begin
            if (!busy) return;
            tick();
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL wait_idle: busy still %0b, required 0", busy);
    endtask

    task automatic checkResetState();
        checkOutput("rst_outValid", 64'(outValid), 64'd0);
        checkOutput("rst_outData", 64'(outData), 64'd0);
        checkOutput("rst_outIndex", 64'(outIndex), 64'd0);
        checkOutput("rst_outFirst", 64'(outFirst), 64'd0);
        checkOutput("rst_outLast", 64'(outLast), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_overrunCount", 64'(overrunCount), 64'd0);
    endtask

    // Scoreboard: while valid, outputs must match the queue head; the head only
    // leaves on a transfer, so a stalled beat is rechecked every cycle.
    always @(negedge clk) begin
        if (rst && outValid) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_beat: index %0d with nothing expected", outIndex);
            end else begin
                monExp = sbq[0];
                vectors++;
                if (outIndex !== 7'(monExp.idx) || outData !== monExp.d0 || outData4 !== monExp.d4 ||
                    outFirst !== (monExp.idx == 0) || outLast !== (monExp.idx == NB - 1) || busy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL beat: got idx=%0d d0=%h d4=%h first=%b last=%b busy=%b, required idx=%0d d0=%h d4=%h first=%b last=%b busy=1",
                             outIndex, outData, outData4, outFirst, outLast, busy,
                             monExp.idx, monExp.d0, monExp.d4, monExp.idx == 0, monExp.idx == NB - 1);
                end
                if (outIndex < 7'(NB)) begin
                    got0[outIndex] = outData;
                    got4[outIndex] = outData4;
                end
                if (outReady) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        vecs[0] = '{0,   36'd2788405,      32'd2788405,   32'd174275};
        vecs[1] = '{5,   36'hF_FFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[2] = '{6,   36'h0_FFFF_FFFF,  32'hFFFF_FFFF, 32'h0FFF_FFFF};
        vecs[3] = '{7,   36'h1_0000_0000,  32'hFFFF_FFFF, 32'h1000_0000};
        vecs[4] = '{8,   36'h0_0000_0000,  32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{9,   36'h0_0000_000F,  32'h0000_000F, 32'h0000_0000};
        vecs[6] = '{10,  36'h0_0000_0010,  32'h0000_0010, 32'h0000_0001};
        vecs[7] = '{119, 36'h8_0000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        for (int i = 0; i < NB; i++) inBins[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkResetState();
        rst = 1'b1;
        tick();

        // Latency, scaling and saturation on one full frame
        fillRandom();
        for (int v = 0; v < 8; v++) inBins[vecs[v].idx] = vecs[v].value;
        outReady = 1'b1;
        snapshot = 1'b1;
        pushFrame();
        checkOutput("valid_before_capture", 64'(outValid), 64'd0);
        tick();
        snapshot = 1'b0;
        checkOutput("latency_valid", 64'(outValid), 64'd1);
        checkOutput("latency_index", 64'(outIndex), 64'd0);
        checkOutput("latency_first", 64'(outFirst), 64'd1);
        checkOutput("latency_busy", 64'(busy), 64'd1);
        waitIdle();
        for (int v = 0; v < 8; v++) begin
            checkOutput($sformatf("bin%0d_shift0", vecs[v].idx), 64'(got0[vecs[v].idx]), 64'(vecs[v].exp0));
            checkOutput($sformatf("bin%0d_shift4", vecs[v].idx), 64'(got4[vecs[v].idx]), 64'(vecs[v].exp4));
        end
        checkOutput("frame1_drained", 64'(sbq.size()), 64'd0);
        checkOutput("frame1_idle_valid", 64'(outValid), 64'd0);

        // Random backpressure with live bins churning after capture
        fillRandom();
        applyStimulus();
        for (int c = 0; c < 5000; c++) begin
            if (!busy) break;
            outReady = 1'($urandom_range(0, 1));
            fillRandom();
            tick();
        end
        checkOutput("random_done_busy", 64'(busy), 64'd0);
        checkOutput("random_drained", 64'(sbq.size()), 64'd0);
        outReady = 1'b1;
        tick();

        // Pending request plus one overrun, seamless recapture
        fillRandom();
        applyStimulus();
        waitIndex(40);
        fillRandom();
        snapshot = 1'b1;
        pushFrame();
        tick();
        snapshot = 1'b0;
        checkOutput("pending_overrun0", 64'(overrunCount), 64'd0);
        checkOutput("pending_busy", 64'(busy), 64'd1);
        waitIndex(60);
        snapshot = 1'b1;
        tick();
        snapshot = 1'b0;
        checkOutput("overrun_one", 64'(overrunCount), 64'd1);
        waitIndex(119);
        tick();
        checkOutput("recap_valid", 64'(outValid), 64'd1);
        checkOutput("recap_index", 64'(outIndex), 64'd0);
        checkOutput("recap_first", 64'(outFirst), 64'd1);
        checkOutput("recap_busy", 64'(busy), 64'd1);

        // Request on the last-transfer edge, then a clean end of stream
        waitIndex(119);
        fillRandom();
        snapshot = 1'b1;
        pushFrame();
        tick();
        snapshot = 1'b0;
        checkOutput("lastedge_valid", 64'(outValid), 64'd1);
        checkOutput("lastedge_index", 64'(outIndex), 64'd0);
        checkOutput("lastedge_overrun", 64'(overrunCount), 64'd1);
        waitIndex(119);
        tick();
        checkOutput("end_valid", 64'(outValid), 64'd0);
        checkOutput("end_busy", 64'(busy), 64'd0);
        checkOutput("end_last", 64'(outLast), 64'd0);
        checkOutput("end_drained", 64'(sbq.size()), 64'd0);

        // Asynchronous reset mid-frame, then a fresh frame
        fillRandom();
        applyStimulus();
        waitIndex(50);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkResetState();
        sbq.delete();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("post_rst_valid", 64'(outValid), 64'd0);
        fillRandom();
        applyStimulus();
        checkOutput("fresh_index", 64'(outIndex), 64'd0);
        checkOutput("fresh_first", 64'(outFirst), 64'd1);
        waitIdle();
        checkOutput("fresh_drained", 64'(sbq.size()), 64'd0);
        checkOutput("fresh_overrun", 64'(overrunCount), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
